shared_reg_arbiter: RTL and testbench

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/npl_pkg.sv | 12 +
 rtl/rr_pick2.sv | 13 +
 rtl/shared_reg_arbiter.sv | 97 +++++++++
 tb/tb_shared_reg_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/npl_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding and default data width.
package npl_pkg;

    localparam int NPL_DW = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t XFER = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/rr_pick2.sv
// Stateless two-way winner selection: a lone requester always wins, a tie goes to ptr.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic winner,
    output logic valid
);

    assign valid  = req0 | req1;
    assign winner = (req0 && req1) ? ptr : req1;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Two-requester arbiter granting access to one shared data register via an IDLE/XFER/DONE FSM.
module shared_reg_arbiter
    import npl_pkg::*;
#(
    parameter int DW = NPL_DW,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] data_out,
    output logic          busy,
    output logic [CW-1:0] txn_count
);

    state_t        state;
    logic          ptr;
    logic          cur_who;
    logic          cur_we;
    logic [DW-1:0] cur_wdata;
    logic          pick_winner;
    logic          pick_valid;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .ptr    (ptr),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign busy = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            cur_who   <= 1'b0;
            cur_we    <= 1'b0;
            cur_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            data_out  <= '0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur_who   <= pick_winner;
                        cur_we    <= pick_winner ? we1 : we0;
                        cur_wdata <= pick_winner ? wdata1 : wdata0;
                        gnt0      <= !pick_winner;
                        gnt1      <= pick_winner;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (cur_we) begin
                        data_out <= cur_wdata;
                    end else begin
                        rdata <= data_out;
                    end
                    // Count and pointer move on entry to DONE so they are visible alongside done.
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    done      <= 1'b1;
                    txn_count <= txn_count + CW'(1);
                    ptr       <= !cur_who;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, a monitor pops them on each done pulse.
module tb_shared_reg_arbiter;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done, busy;
    logic [DW-1:0] rdata, data_out;
    logic [CW-1:0] txn_count;

    typedef struct {
        int            who;
        logic [DW-1:0] rdata;
        logic [DW-1:0] dout;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // bench model of the architecturally visible state
    logic [DW-1:0] m_reg;
    logic [DW-1:0] m_rdata;
    logic [CW-1:0] m_cnt;

    shared_reg_arbiter #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done      (done),
        .rdata     (rdata),
        .data_out  (data_out),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input int who, input bit wr, input logic [DW-1:0] wd);
        exp_t e;
        if (wr) m_reg = wd;
        else    m_rdata = m_reg;
        m_cnt   = m_cnt + CW'(1);
        e.who   = who;
        e.rdata = m_rdata;
        e.dout  = m_reg;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endtask

    // Called at a negedge in IDLE; keeps requests up exactly long enough for n samples.
    task automatic run_held(input bit r0, input bit r1, input int n);
        req0 = r0;
        req1 = r1;
        repeat (3 * n - 2) @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: protocol checks every cycle, scoreboard compare on each done pulse.
    initial begin
        int   gcyc;
        int   gwho;
        exp_t e;
        gcyc = 0;
        gwho = -1;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                gcyc = 0;
            end else begin
                check("gnt_exclusive", {30'd0, gnt0 & gnt1, done & (gnt0 | gnt1)}, 32'd0);
                if (gnt0 || gnt1) begin
                    gcyc++;
                    gwho = gnt1 ? 1 : 0;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("grant_who", gwho, e.who);
                        check("grant_cycles", gcyc, 32'd1);
                        check("rdata", 32'(rdata), 32'(e.rdata));
                        check("data_out", 32'(data_out), 32'(e.dout));
                        check("txn_count", 32'(txn_count), 32'(e.cnt));
                        check("busy_in_done", 32'(busy), 32'd1);
                    end
                    gcyc = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        wdata0 = '0; wdata1 = '0;
        m_reg = '0; m_rdata = '0; m_cnt = '0;
        #1;
        check("rst_gnt",   {30'd0, gnt0, gnt1}, 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_dout",  32'(data_out), 32'd0);
        check("rst_count", 32'(txn_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single write of 12 from requester 0
        we0 = 1'b1; wdata0 = 16'd12;
        expect_txn(0, 1'b1, 16'd12);
        run_held(1'b1, 1'b0, 1);

        // read-after-write from requester 1
        we1 = 1'b0;
        expect_txn(1, 1'b0, '0);
        run_held(1'b0, 1'b1, 1);

        // contention: both held, grants alternate starting with requester 0
        we0 = 1'b1; wdata0 = 16'd1;
        we1 = 1'b1; wdata1 = 16'd5;
        expect_txn(0, 1'b1, 16'd1);
        expect_txn(1, 1'b1, 16'd5);
        expect_txn(0, 1'b1, 16'd1);
        expect_txn(1, 1'b1, 16'd5);
        run_held(1'b1, 1'b1, 4);

        // req pulsed one cycle; wdata/we changed during XFER must be ignored
        we0 = 1'b1; wdata0 = 16'd7;
        expect_txn(0, 1'b1, 16'd7);
        req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; wdata0 = 16'd9; we0 = 1'b0;
        repeat (2) @(negedge clk);
        check("drop_dout", 32'(data_out), 32'd7);

        // restore 12, then abort a write of 5 by reset during XFER
        we0 = 1'b1; wdata0 = 16'd12;
        expect_txn(0, 1'b1, 16'd12);
        run_held(1'b1, 1'b0, 1);
        wdata0 = 16'd5;
        req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        check("xfer_gnt0", 32'(gnt0), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_gnt",   {30'd0, gnt0, gnt1}, 32'd0);
        check("abort_done",  32'(done), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_rdata", 32'(rdata), 32'd0);
        check("abort_dout",  32'(data_out), 32'd0);
        check("abort_count", 32'(txn_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_reg = '0; m_rdata = '0; m_cnt = '0;
        repeat (2) @(negedge clk);
        check("post_abort_dout", 32'(data_out), 32'd0);

        // pointer back at requester 0 after reset
        we0 = 1'b1; wdata0 = 16'd12;
        we1 = 1'b1; wdata1 = 16'd5;
        expect_txn(0, 1'b1, 16'd12);
        run_held(1'b1, 1'b1, 1);

        // counter wrap: 255 more reads bring the total to 256
        we0 = 1'b0;
        for (int i = 0; i < 255; i++) expect_txn(0, 1'b0, '0);
        run_held(1'b1, 1'b0, 255);
        repeat (2) @(negedge clk);
        check("wrap_count", 32'(txn_count), 32'd0);
        check("wrap_busy",  32'(busy), 32'd0);
        check("wrap_dout",  32'(data_out), 32'd12);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
